sram_array_banked_ctrl: RTL and testbench
=========================================

Name: sram_array_banked_ctrl

Overview:
- Parametrised successor to the distributed SRAM bank array: COUNT lane banks, each DATA_WIDTH x HEIGHT, sharing one address.
- Adds a valid/ready request port, per-lane write masks and a configurable read pipeline latency.
- Adds a read-modify-write accumulate op (Q-value update path) and a hardware clear sweep.
- Sits between the RL update engine and the MAC array as Q-table / weight storage.

Parameters:
- COUNT, 128, number of lanes (banks).
- DATA_WIDTH, 16, bits per lane word.
- HEIGHT, 128, rows per bank; must be <= 2**ADDR_BITS.
- ADDR_BITS, 7, address width.
- READ_LAT, 1, read latency in cycles; legal range 1..4.
- ACC_SATURATE, 0, 0 = accumulate wraps mod 2**DATA_WIDTH; 1 = signed two's-complement saturation.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  2  00 read, 01 write, 10 accumulate, 11 clear.
- req_addr  in  ADDR_BITS  row address; ignored for clear.
- req_lane_mask  in  COUNT  per-lane enable for write and accumulate; ignored for read and clear.
- req_data  in  DATA_WIDTH*COUNT  write data or accumulate addend; lane i is bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- rd_valid  out  1  read data valid, one-cycle pulse per read.
- rd_data  out  DATA_WIDTH*COUNT  read data, same lane packing as req_data.
- busy  out  1  accumulate or clear in progress.

Behaviour:
- Reset (rst_b low, asynchronous):
  - FSM goes to IDLE and the read pipeline is flushed.
  - req_ready=1, rd_valid=0, rd_data=0, busy=0.
  - Memory contents are not reset; they are undefined until written or cleared.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. At most one request per cycle.
- FSM states: IDLE, ACC_WR, CLEAR.
  - req_ready = (state==IDLE).
  - busy = (state!=IDLE).
- READ:
  - The row is sampled at the accept edge.
  - rd_valid and rd_data are high for exactly one cycle, beginning READ_LAT cycles after the accept edge (READ_LAT=1: the cycle right after acceptance).
  - Back-to-back reads are fully pipelined, one result per cycle, in order.
  - rd_data holds its last value when rd_valid=0.
- WRITE:
  - At the accept edge, lanes with req_lane_mask[i]=1 are written; other lanes are unchanged.
  - A read accepted on the next edge returns the new data.
  - A mask of all zeros is a legal no-op.
- ACCUMULATE:
  - Accept edge k: the row is read and address, mask and addend are captured; FSM goes to ACC_WR (req_ready=0 during the following cycle).
  - Edge k+1: masked lanes are written with stored+addend; FSM returns to IDLE.
  - Arithmetic is full DATA_WIDTH per lane.
    - ACC_SATURATE=0: wraps.
    - ACC_SATURATE=1: clamps to +(2**(DATA_WIDTH-1))-1 or -(2**(DATA_WIDTH-1)).
  - No rd_valid is generated for an accumulate.
- CLEAR:
  - Accept edge k: FSM goes to CLEAR with row counter 0.
  - On each following edge it writes zero to all lanes of the counter row, then increments.
  - After row HEIGHT-1 is written (edge k+HEIGHT) it returns to IDLE.
  - Clear takes exactly HEIGHT busy cycles.
- In-flight reads: reads accepted before an accumulate or clear still deliver their originally sampled data on schedule.
- Out-of-range address (req_addr >= HEIGHT): write and accumulate are ignored; a read returns all zeros with normal rd_valid timing.
- Reset mid-operation: an accumulate or clear is aborted immediately. Rows not yet written keep old contents; the row being written at the reset edge is undefined.
- Ready rule: req_ready never depends combinationally on req_valid.

Test Plan:
Bench configuration: COUNT=4, DATA_WIDTH=16, HEIGHT=8, ADDR_BITS=3, READ_LAT=2.
- Clear then read addr 5 -> busy high 8 cycles, req_ready low 8 cycles; the read returns 0x0000 on all lanes, rd_valid 2 cycles after acceptance.
- Write addr 3, data lanes {0x1111,0x2222,0x3333,0x4444}, mask 0101; then read addr 3 -> lanes {0x1111,0x0000,0x3333,0x0000} (post-clear).
- Reads to addrs 0..7 on consecutive cycles after distinct writes -> 8 consecutive rd_valid pulses, in order, first one 2 cycles after the first accept.
- ACC_SATURATE=0:
  - Addr 2 holds 0xFFFF; accumulate +0x0002, mask 0001.
  - Expect req_ready low for 1 cycle; a read then returns lane0=0x0001.
- ACC_SATURATE=1:
  - Lane0 holds 0x7FF0; accumulate +0x0100 -> 0x7FFF.
  - Lane1 holds 0x8005; accumulate +0xFF00 -> 0x8000.
- Assert rst_b low 3 cycles into a clear with a read in flight -> rd_valid=0, busy=0, req_ready=1 immediately; rows 0-1 read back 0, rows 4-7 keep pre-clear values.

Source files
------------

// File: rtl/sram_array_banked_ctrl.sv
// sram_array_banked_ctrl
// COUNT lane banks of DATA_WIDTH x HEIGHT words sharing one row address.
// A valid/ready request port supports read, masked write, masked
// read-modify-write accumulate and a full-array clear sweep. Read data comes
// out of a READ_LAT-deep pipeline, so reads can be issued back to back.
//
// Ports:
//   clk           clock, rising edge
//   rst_b         asynchronous active-low reset
//   req_valid     request present
//   req_ready     request can be accepted this cycle (FSM idle)
//   req_op        00 read, 01 write, 10 accumulate, 11 clear
//   req_addr      row address (ignored for clear)
//   req_lane_mask per-lane enable for write / accumulate
//   req_data      write data or accumulate addend, lane i at [i*DW +: DW]
//   rd_valid      one-cycle pulse per read result
//   rd_data       read result, same packing as req_data; holds when idle
//   busy          accumulate or clear in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | accepting requests; reads and writes complete here
// ST_ACC_WR | writing back stored+addend for the captured accumulate
// ST_CLEAR  | zeroing row r_clr_row each cycle, rows 0..HEIGHT-1

module sram_array_banked_ctrl #(
   parameter int COUNT        = 128,
   parameter int DATA_WIDTH   = 16,
   parameter int HEIGHT       = 128,
   parameter int ADDR_BITS    = 7,
   parameter int READ_LAT     = 1,
   parameter int ACC_SATURATE = 0
) (
   input  logic                          clk,
   input  logic                          rst_b,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [1:0]                    req_op,
   input  logic [ADDR_BITS-1:0]          req_addr,
   input  logic [COUNT-1:0]              req_lane_mask,
   input  logic [DATA_WIDTH*COUNT-1:0]   req_data,
   output logic                          rd_valid,
   output logic [DATA_WIDTH*COUNT-1:0]   rd_data,
   output logic                          busy
);

   localparam int LW = DATA_WIDTH * COUNT;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ACC   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACC_WR = 2'd1;
   localparam logic [1:0] ST_CLEAR  = 2'd2;

   // One extra bit so HEIGHT == 2**ADDR_BITS is representable.
   localparam logic [ADDR_BITS:0]   HEIGHT_W = (ADDR_BITS+1)'(HEIGHT);
   localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(HEIGHT - 1);

   logic [DATA_WIDTH-1:0] r_mem [HEIGHT][COUNT];

   logic [1:0]            r_state;
   logic [ADDR_BITS-1:0]  r_clr_row;
   logic [ADDR_BITS-1:0]  r_acc_addr;
   logic                  r_acc_in_range;
   logic [COUNT-1:0]      r_acc_mask;
   logic [LW-1:0]         r_acc_old;
   logic [LW-1:0]         r_acc_add;

   logic [READ_LAT-1:0]   r_pv;
   logic [LW-1:0]         r_pd [READ_LAT];

   logic                  w_accept;
   logic                  w_in_range;
   logic [LW-1:0]         w_row;
   logic [LW-1:0]         w_acc_sum;
   logic [DATA_WIDTH-1:0] w_a;
   logic [DATA_WIDTH-1:0] w_b;
   logic [DATA_WIDTH:0]   w_ext;

   assign req_ready  = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign w_accept   = req_valid && req_ready;
   assign w_in_range = ({1'b0, req_addr} < HEIGHT_W);

   // Out-of-range rows read as zero.
   always_comb begin
      w_row = '0;
      if (w_in_range) begin
         for (int i = 0; i < COUNT; i++) begin
            w_row[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[req_addr][i];
         end
      end
   end

   // Sign-extended add; bits DW and DW-1 disagree exactly on signed overflow.
   always_comb begin
      w_acc_sum = '0;
      w_a       = '0;
      w_b       = '0;
      w_ext     = '0;
      for (int i = 0; i < COUNT; i++) begin
         w_a   = r_acc_old[i*DATA_WIDTH +: DATA_WIDTH];
         w_b   = r_acc_add[i*DATA_WIDTH +: DATA_WIDTH];
         w_ext = {w_a[DATA_WIDTH-1], w_a} + {w_b[DATA_WIDTH-1], w_b};
         if ((ACC_SATURATE != 0) && (w_ext[DATA_WIDTH] != w_ext[DATA_WIDTH-1])) begin
            w_acc_sum[i*DATA_WIDTH +: DATA_WIDTH] = w_ext[DATA_WIDTH] ?
               {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
         end else begin
            w_acc_sum[i*DATA_WIDTH +: DATA_WIDTH] = w_ext[DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state        <= ST_IDLE;
         r_clr_row      <= '0;
         r_acc_addr     <= '0;
         r_acc_in_range <= 1'b0;
         r_acc_mask     <= '0;
         r_acc_old      <= '0;
         r_acc_add      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && req_op == OP_ACC) begin
                  r_state        <= ST_ACC_WR;
                  r_acc_addr     <= req_addr;
                  r_acc_in_range <= w_in_range;
                  r_acc_mask     <= req_lane_mask;
                  r_acc_old      <= w_row;
                  r_acc_add      <= req_data;
               end else if (w_accept && req_op == OP_CLEAR) begin
                  r_state   <= ST_CLEAR;
                  r_clr_row <= '0;
               end
            end
            ST_ACC_WR: r_state <= ST_IDLE;
            ST_CLEAR: begin
               if (r_clr_row == LAST_ROW) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_clr_row <= r_clr_row + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Storage has no reset; an aborted op simply stops issuing writes because
   // r_state drops to idle asynchronously.
   always_ff @(posedge clk) begin
      if (w_accept && req_op == OP_WRITE && w_in_range) begin
         for (int i = 0; i < COUNT; i++) begin
            if (req_lane_mask[i]) r_mem[req_addr][i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end else if (r_state == ST_ACC_WR && r_acc_in_range) begin
         for (int i = 0; i < COUNT; i++) begin
            if (r_acc_mask[i]) r_mem[r_acc_addr][i] <= w_acc_sum[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end else if (r_state == ST_CLEAR) begin
         for (int i = 0; i < COUNT; i++) begin
            r_mem[r_clr_row][i] <= '0;
         end
      end
   end

   // Stage 0 loads at the accept edge; later stages only move on valid so the
   // last stage (the output) holds its value between pulses.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_pv <= '0;
         for (int s = 0; s < READ_LAT; s++) r_pd[s] <= '0;
      end else begin
         r_pv[0] <= w_accept && (req_op == OP_READ);
         if (w_accept && req_op == OP_READ) r_pd[0] <= w_row;
         for (int s = 1; s < READ_LAT; s++) begin
            r_pv[s] <= r_pv[s-1];
            if (r_pv[s-1]) r_pd[s] <= r_pd[s-1];
         end
      end
   end

   assign rd_valid = r_pv[READ_LAT-1];
   assign rd_data  = r_pd[READ_LAT-1];

endmodule

// File: tb/tb_sram_array_banked_ctrl.sv
// Directed bench for sram_array_banked_ctrl with COUNT=4, DATA_WIDTH=16,
// HEIGHT=8, ADDR_BITS=3, READ_LAT=2. Two instances share all inputs: u_dut
// wraps on accumulate, u_dut_sat saturates.

module tb_sram_array_banked_ctrl;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [2:0]  req_addr;
   logic [3:0]  req_lane_mask;
   logic [63:0] req_data;

   logic        rdy_w, rv_w, busy_w;
   logic [63:0] rd_w;
   logic        rdy_s, rv_s, busy_s;
   logic [63:0] rd_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram_array_banked_ctrl #(
      .COUNT(4), .DATA_WIDTH(16), .HEIGHT(8), .ADDR_BITS(3), .READ_LAT(2), .ACC_SATURATE(0)
   ) u_dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(rdy_w),
      .req_op(req_op), .req_addr(req_addr), .req_lane_mask(req_lane_mask),
      .req_data(req_data), .rd_valid(rv_w), .rd_data(rd_w), .busy(busy_w)
   );

   sram_array_banked_ctrl #(
      .COUNT(4), .DATA_WIDTH(16), .HEIGHT(8), .ADDR_BITS(3), .READ_LAT(2), .ACC_SATURATE(1)
   ) u_dut_sat (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(rdy_s),
      .req_op(req_op), .req_addr(req_addr), .req_lane_mask(req_lane_mask),
      .req_data(req_data), .rd_valid(rv_s), .rd_data(rd_s), .busy(busy_s)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the request for exactly one edge; returns just after that edge.
   task automatic issue(input logic [1:0] op, input logic [2:0] addr,
                        input logic [3:0] mask, input logic [63:0] data);
      req_valid     = 1'b1;
      req_op        = op;
      req_addr      = addr;
      req_lane_mask = mask;
      req_data      = data;
      step();
      req_valid     = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] addr,
                         input logic [63:0] exp_w, input logic [63:0] exp_s);
      issue(OP_RD, addr, 4'h0, 64'h0);
      chk({tag, "_lat"}, rv_w, 1'b0);
      step();
      chk({tag, "_vld"}, rv_w, 1'b1);
      chk({tag, "_svld"}, rv_s, 1'b1);
      chk({tag, "_w"}, rd_w, exp_w);
      chk({tag, "_s"}, rd_s, exp_s);
   endtask

   function automatic logic [63:0] pat(input int r);
      return {16'(16'h4000 + r), 16'(16'h3000 + r), 16'(16'h2000 + r), 16'(16'h1000 + r)};
   endfunction

   initial begin
      int n;
      rst_b         = 1'b0;
      req_valid     = 1'b0;
      req_op        = OP_RD;
      req_addr      = '0;
      req_lane_mask = '0;
      req_data      = '0;
      repeat (3) step();
      chk("rst_rdy", rdy_w, 1'b1);
      chk("rst_vld", rv_w, 1'b0);
      chk("rst_dat", rd_w, 64'h0);
      chk("rst_busy", busy_w, 1'b0);
      rst_b = 1'b1;
      step();

      // Clear sweep: exactly 8 busy cycles with ready low throughout.
      issue(OP_CLR, 3'd0, 4'h0, 64'h0);
      n = 0;
      while (busy_w && n < 20) begin
         chk("clr_rdy_low", rdy_w, 1'b0);
         n++;
         step();
      end
      chk("clr_cycles", 64'(n), 64'd8);
      chk("clr_rdy_back", rdy_w, 1'b1);
      rd_chk("clr_rd5", 3'd5, 64'h0, 64'h0);
      rd_chk("clr_rd0", 3'd0, 64'h0, 64'h0);
      rd_chk("clr_rd7", 3'd7, 64'h0, 64'h0);

      // Masked write, then hold of rd_data after the pulse.
      issue(OP_WR, 3'd3, 4'b0101, 64'h4444_3333_2222_1111);
      rd_chk("wr_mask", 3'd3, 64'h0000_3333_0000_1111, 64'h0000_3333_0000_1111);
      step();
      chk("rd_hold_vld", rv_w, 1'b0);
      chk("rd_hold_dat", rd_w, 64'h0000_3333_0000_1111);
      issue(OP_WR, 3'd3, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
      rd_chk("wr_mask0", 3'd3, 64'h0000_3333_0000_1111, 64'h0000_3333_0000_1111);

      // Distinct rows, then 8 back-to-back reads.
      for (int r = 0; r < 8; r++) issue(OP_WR, 3'(r), 4'hF, pat(r));
      req_op = OP_RD;
      for (int a = 0; a < 8; a++) begin
         req_valid = 1'b1;
         req_addr  = 3'(a);
         step();
         if (a == 0) begin
            chk("pipe_lat", rv_w, 1'b0);
         end else begin
            chk("pipe_vld", rv_w, 1'b1);
            chk("pipe_dat", rd_w, pat(a - 1));
         end
      end
      req_valid = 1'b0;
      step();
      chk("pipe_vld7", rv_w, 1'b1);
      chk("pipe_dat7", rd_w, pat(7));
      step();
      chk("pipe_end", rv_w, 1'b0);

      // Accumulate wrap on lane0: 0xFFFF + 2 -> 0x0001.
      issue(OP_WR, 3'd2, 4'b0001, 64'h0000_0000_0000_FFFF);
      issue(OP_ACC, 3'd2, 4'b0001, 64'h0000_0000_0000_0002);
      chk("acc_rdy_low", rdy_w, 1'b0);
      chk("acc_busy", busy_w, 1'b1);
      chk("acc_no_rv", rv_w, 1'b0);
      step();
      chk("acc_rdy_back", rdy_w, 1'b1);
      chk("acc_rdy_back_s", rdy_s, 1'b1);
      rd_chk("acc_wrap", 3'd2, 64'h4002_3002_2002_0001, 64'h4002_3002_2002_0001);

      // Saturation vs wrap on row 6; lane2 masked off.
      issue(OP_WR, 3'd6, 4'hF, 64'h0001_1234_8005_7FF0);
      issue(OP_ACC, 3'd6, 4'b1011, 64'hFFFF_0001_FF00_0100);
      step();
      rd_chk("acc_sat", 3'd6, 64'h0000_1234_7F05_80F0, 64'h0000_1234_8000_7FFF);

      // Read in flight across a clear accept, then reset mid-clear.
      req_valid = 1'b1;
      req_op    = OP_RD;
      req_addr  = 3'd7;
      step();
      req_op    = OP_CLR;
      step();
      req_valid = 1'b0;
      chk("fly_vld", rv_w, 1'b1);
      chk("fly_dat", rd_w, pat(7));
      chk("fly_busy", busy_w, 1'b1);
      step();
      step();
      rst_b = 1'b0;
      #1;
      chk("abort_busy", busy_w, 1'b0);
      chk("abort_busy_s", busy_s, 1'b0);
      chk("abort_rdy", rdy_w, 1'b1);
      chk("abort_vld", rv_w, 1'b0);
      chk("abort_dat", rd_w, 64'h0);
      step();
      step();
      rst_b = 1'b1;
      step();
      rd_chk("abort_rd0", 3'd0, 64'h0, 64'h0);
      rd_chk("abort_rd1", 3'd1, 64'h0, 64'h0);
      rd_chk("abort_rd4", 3'd4, pat(4), pat(4));
      rd_chk("abort_rd5", 3'd5, pat(5), pat(5));
      rd_chk("abort_rd6", 3'd6, 64'h0000_1234_7F05_80F0, 64'h0000_1234_8000_7FFF);
      rd_chk("abort_rd7", 3'd7, pat(7), pat(7));

      // Reset flushes a read still inside the pipeline.
      issue(OP_RD, 3'd4, 4'h0, 64'h0);
      rst_b = 1'b0;
      step();
      chk("flush_vld", rv_w, 1'b0);
      chk("flush_dat", rd_w, 64'h0);
      rst_b = 1'b1;
      step();
      chk("flush_after", rv_w, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
